// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream engine.
package fifo_rd_pkg;

  localparam logic [2:0] SKID_DEPTH = 3'd3;

  typedef logic [1:0]  occ_t;
  typedef logic [15:0] wcnt_t;

  // Circular pointer advance over the three buffer slots.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Three-entry circular buffer absorbing the FIFO's read latency; storage only.
module fifo_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] mem [0:SKID_DEPTH-1];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  occ_t             occ_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ_q  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // NOTE: the data array has no reset; occupancy and pointers alone decide
  // which slots are meaningful, so clearing storage would only cost logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign occ       = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops words from a synchronous FIFO and presents them as a packetised
// valid/ready stream at one word per clock.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int PKT_LEN = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  output logic             rd_en_o,
  input  logic [WIDTH-1:0] rd_data_i,
  input  logic             empty_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             last_o,
  output logic [15:0]      word_cnt_o
);

  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

  logic              en_q;
  logic              infl_q;
  logic [BEAT_W-1:0] beat_q;
  wcnt_t             word_cnt_q;
  occ_t              occ;
  logic [WIDTH-1:0]  head;
  logic [2:0]        credit_used;
  logic              xfer;

  fifo_skid_buf #(.WIDTH(WIDTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (infl_q),
    .push_data (rd_data_i),
    .pop       (xfer),
    .head_data (head),
    .occ       (occ)
  );

  // Credit counts words already buffered plus the one still in flight, so a
  // capture always finds a free slot without looking at ready_i.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    credit_used = 3'd0;
    rd_en_o     = 1'b0;
    credit_used = {1'b0, occ} + {2'b00, infl_q};
    rd_en_o     = en_q & ~empty_i & (credit_used < SKID_DEPTH);
  end

  assign valid_o    = (occ != 2'd0);
  assign data_o     = valid_o ? head : '0;
  assign last_o     = valid_o & (beat_q == BEAT_LAST);
  assign xfer       = valid_o & ready_i;
  assign word_cnt_o = word_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      infl_q     <= 1'b0;
      beat_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      en_q   <= enable_i;
      infl_q <= rd_en_o;
      if (xfer) begin
        beat_q     <= (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);
        word_cnt_q <= word_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader driving a behavioural FIFO model.
module tb_fifo_stream_reader;

  localparam int WIDTH   = 4;
  localparam int PKT_LEN = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable_i;
  logic             rd_en_o;
  logic [WIDTH-1:0] rd_data_i;
  logic             empty_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             ready_i;
  logic             last_o;
  logic [15:0]      word_cnt_o;

  fifo_stream_reader #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (enable_i),
    .rd_en_o    (rd_en_o),
    .rd_data_i  (rd_data_i),
    .empty_i    (empty_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .last_o     (last_o),
    .word_cnt_o (word_cnt_o)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: one-cycle read latency, empty from the pointers.
  logic [WIDTH-1:0] fifo_mem [64];
  logic [5:0]       fifo_rd_ptr;
  logic [5:0]       fifo_wr_ptr;
  logic             fifo_wr;
  logic [WIDTH-1:0] fifo_wdata;
  logic             fifo_clr;

  always @(posedge clk) begin
    if (fifo_clr) begin
      fifo_rd_ptr <= '0;
      fifo_wr_ptr <= '0;
      rd_data_i   <= '0;
    end else begin
      if (fifo_wr) begin
        fifo_mem[fifo_wr_ptr] <= fifo_wdata;
        fifo_wr_ptr <= fifo_wr_ptr + 6'd1;
      end
      if (rd_en_o && !empty_i) begin
        rd_data_i   <= fifo_mem[fifo_rd_ptr];
        fifo_rd_ptr <= fifo_rd_ptr + 6'd1;
      end
    end
  end

  assign empty_i = (fifo_rd_ptr == fifo_wr_ptr);

  int               n_checks = 0;
  int               n_err    = 0;
  logic [WIDTH-1:0] exp_q [$];
  int               beat_m;
  int               wcnt_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    enable_i = 1'b0;
    ready_i  = 1'b0;
    fifo_wr  = 1'b0;
    fifo_clr = 1'b1;
    fifo_wdata = '0;
    exp_q.delete();
    beat_m = 0;
    wcnt_m = 0;
    repeat (2) @(negedge clk);
    fifo_clr = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
  endtask

  task automatic prefill(input logic [WIDTH-1:0] w);
    fifo_wr    = 1'b1;
    fifo_wdata = w;
    exp_q.push_back(w);
    @(negedge clk);
    fifo_wr = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rd_en"},    rd_en_o,    0);
    check({tag, "_valid"},    valid_o,    0);
    check({tag, "_last"},     last_o,     0);
    check({tag, "_data"},     data_o,     0);
    check({tag, "_word_cnt"}, word_cnt_o, 0);
  endtask

  // Sink with scoreboard: order, last framing, stall stability, word count.
  task automatic run_stream(input int n, input bit rnd, input int max_cyc);
    int               got        = 0;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;
    for (int c = 0; c < max_cyc && got < n; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        check("stall_valid", valid_o, 1);
        check("stall_data",  data_o,  prev_data);
      end
      ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL extra_word: got %0h expected no word", data_o);
        end else begin
          check("stream_data", data_o, exp_q.pop_front());
          check("stream_last", last_o, (beat_m == PKT_LEN - 1) ? 1 : 0);
        end
        beat_m = (beat_m == PKT_LEN - 1) ? 0 : beat_m + 1;
        wcnt_m++;
        got++;
      end
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o;
    end
    check("stream_count", got, n);
    @(negedge clk);
    check("word_cnt", word_cnt_o, wcnt_m);
  endtask

  typedef struct {
    logic             enable;
    logic             ready;
    logic             rd_en;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             last;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic       rd_exp [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int         pops;
    logic [3:0] pre   [5] = '{4'h5, 4'hA, 4'h3, 4'hF, 4'h0};

    // Per-cycle expectations after enable; inputs apply to the next edge.
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};

    // Reset state and full-rate packet.
    do_reset();
    check_idle("reset");
    for (int i = 0; i < 5; i++) prefill(pre[i]);
    enable_i = 1'b1;
    ready_i  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d_rd_en", i), rd_en_o, vecs[i].rd_en);
      check($sformatf("vec%0d_valid", i), valid_o, vecs[i].valid);
      check($sformatf("vec%0d_data",  i), data_o,  vecs[i].data);
      check($sformatf("vec%0d_last",  i), last_o,  vecs[i].last);
      enable_i = vecs[i].enable;
      ready_i  = vecs[i].ready;
    end
    check("full_rate_word_cnt", word_cnt_o, 5);

    // Backpressure: buffer fills to three, then pops stop.
    do_reset();
    for (int i = 0; i < 5; i++) prefill(pre[i]);
    enable_i = 1'b1;
    ready_i  = 1'b0;
    pops = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("stall_c%0d_rd_en", c), rd_en_o, rd_exp[c]);
      pops += int'(rd_en_o);
      if (c >= 2) begin
        check("stall_hold_valid", valid_o, 1);
        check("stall_hold_data",  data_o,  4'h5);
      end
    end
    check("stall_pop_count", pops, 3);
    run_stream(5, 1'b0, 40);

    // Random backpressure over four packets.
    do_reset();
    for (int i = 0; i < 20; i++) prefill(4'($urandom_range(0, 15)));
    enable_i = 1'b1;
    run_stream(20, 1'b1, 300);
    check("random_drained", valid_o, 0);

    // Enable withdrawn while the second pop is issued: two words, beat held.
    do_reset();
    for (int i = 1; i <= 5; i++) prefill(4'(i));
    enable_i = 1'b1;
    ready_i  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    enable_i = 1'b0;
    run_stream(2, 1'b0, 20);
    repeat (5) begin
      @(negedge clk);
      check("disabled_rd_en", rd_en_o, 0);
      check("disabled_valid", valid_o, 0);
    end
    check("disabled_word_cnt", word_cnt_o, 2);
    enable_i = 1'b1;
    run_stream(3, 1'b0, 30);

    // Mid-operation reset with two buffered words and one in flight.
    do_reset();
    for (int i = 8; i < 14; i++) prefill(4'(i));
    enable_i = 1'b1;
    ready_i  = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_valid", valid_o, 1);
    check("pre_reset_data",  data_o,  4'h8);
    rst_n = 1'b0;
    #1;
    check_idle("mid_reset");
    @(negedge clk);
    rst_n  = 1'b1;
    beat_m = 0;
    wcnt_m = 0;
    exp_q.delete();
    exp_q.push_back(4'hB);
    exp_q.push_back(4'hC);
    exp_q.push_back(4'hD);
    run_stream(3, 1'b0, 30);
    check("post_reset_drained", valid_o, 0);

    // Empty FIFO: nothing popped, nothing presented.
    do_reset();
    enable_i = 1'b1;
    ready_i  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("empty_rd_en", rd_en_o, 0);
      check("empty_valid", valid_o, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
